// File: rtl/axi_burst_mem.sv
// axi_burst_mem: single-port AXI4 burst memory slave.
// Serves one burst at a time (FIXED/INCR/WRAP) with byte strobes and SLVERR
// reporting; read and write requests share the array under round-robin.
module axi_burst_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  // write data
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  // write response
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  // read address
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  // read data
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BLOG  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // Records which channel won the last grant; resets so that a read wins the
  // first tie after reset.
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  mem_we;
  logic                  grant_wr, grant_rd;
  logic                  last_beat, oor_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDXW'(addr >> BLOG);
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> BLOG) >= ADDR_WIDTH'(DEPTH);
  endfunction

  function automatic logic req_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic                  wrap;
    step = ONE << size;
    wrap = (burst == BURST_WRAP);
    return (size > 3'(BLOG)) || (burst == BURST_RSVD) ||
           (wrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
           (wrap && ((addr & (step - ONE)) != '0));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic [7:0] len, input logic [2:0] size,
                                                    input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, total;
    step  = ONE << size;
    total = step * (ADDR_WIDTH'(len) + ONE);
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP)  return (addr & ~(total - ONE)) | ((addr + step) & (total - ONE));
    return (addr & ~(step - ONE)) + step;
  endfunction

  // Next-state, handshake outputs and datapath updates for the burst engine.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    mem_we       = 1'b0;
    awready_o    = 1'b0;
    arready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    bresp_o      = RESP_OKAY;
    rvalid_o     = 1'b0;
    rlast_o      = 1'b0;
    last_beat    = (beat_q == len_q);
    addr_next    = advance(addr_q, len_q, size_q, burst_q);
    oor_next     = out_of_range(addr_next);
    grant_wr     = !rst && (state_q == IDLE) && awvalid_i &&
                   (!arvalid_i || (last_grant_q == GRANT_RD));
    grant_rd     = !rst && (state_q == IDLE) && arvalid_i && !grant_wr;

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          awready_o    = 1'b1;
          last_grant_d = GRANT_WR;
          addr_d       = awaddr_i;
          len_d        = awlen_i;
          size_d       = awsize_i;
          burst_d      = awburst_i;
          beat_d       = '0;
          err_d        = req_bad(awaddr_i, awlen_i, awsize_i, awburst_i);
          state_d      = WR_DATA;
        end else if (grant_rd) begin
          arready_o    = 1'b1;
          last_grant_d = GRANT_RD;
          addr_d       = araddr_i;
          len_d        = arlen_i;
          size_d       = arsize_i;
          burst_d      = arburst_i;
          beat_d       = '0;
          err_d        = req_bad(araddr_i, arlen_i, arsize_i, arburst_i);
          rdata_d      = out_of_range(araddr_i) ? '0 : mem_q[word_idx(araddr_i)];
          rresp_d      = (err_d || out_of_range(araddr_i)) ? RESP_SLVERR : RESP_OKAY;
          state_d      = RD_DATA;
        end
      end
      WR_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we = !out_of_range(addr_q);
          err_d  = err_q || out_of_range(addr_q) || (wlast_i != last_beat);
          addr_d = addr_next;
          if (last_beat) state_d = WR_RESP;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      WR_RESP: begin
        bvalid_o = 1'b1;
        bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready_i) state_d = IDLE;
      end
      RD_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = last_beat;
        if (rready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            rdata_d = oor_next ? '0 : mem_q[word_idx(addr_next)];
            rresp_d = (err_q || oor_next) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and read-data registers; reset returns the engine to IDLE.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_WR;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  // Byte-strobed array write; lanes come from wstrb only.
  // NOTE: the array has no reset, so contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb_i[i]) mem_q[word_idx(addr_q)][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign rresp_o = rresp_q;

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: single and burst transfers, wrap order,
// strobes, error responses, arbitration and asynchronous reset mid-burst.
module tb_axi_burst_mem;

  logic        clk, rst;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  resp;
  int          wl, bl, rlat;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  axi_burst_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full write burst of size 2; bad_last marks a beat whose wlast is inverted.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int bad_last, output logic [1:0] r, output int wlat, output int blat);
    int n;
    awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    #1; n = 0;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    check("aw_handshake", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    wlat = 0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wd[b]; wstrb = ws[b]; wvalid = 1'b1;
      wlast = ((b == int'(len)) != (b == bad_last));
      #1; n = 0;
      while (!wready && n < 50) begin @(negedge clk); #1; n++; end
      if (b == 0) wlat = n;
      check("w_handshake", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1; n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    blat = n;
    check("b_handshake", bvalid, 1);
    r = bresp;
    @(negedge clk); bready = 1'b0;
  endtask

  // Full read burst; stall_beat holds rready low for two cycles on that beat.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall_beat, output int lat);
    int n;
    logic [31:0] hold_data;
    logic        hold_last;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    check("ar_handshake", arready, 1);
    @(negedge clk); arvalid = 1'b0;
    #1; n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    lat = n;
    for (int b = 0; b <= int'(len); b++) begin
      check("r_valid", rvalid, 1);
      if (b == stall_beat) begin
        hold_data = rdata; hold_last = rlast;
        rready = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        check("stall_rvalid", rvalid, 1);
        check("stall_rdata", rdata, hold_data);
        check("stall_rlast", rlast, hold_last);
      end
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast;
      rready = 1'b1;
      @(negedge clk); rready = 1'b0; #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk); rst = 1'b0;

    // Single-beat write then read-back, with latency checks.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h10, 8'd0, INCR, -1, resp, wl, bl);
    check("t1_bresp", resp, 2'b00);
    check("t1_wready_lat", wl, 0);
    check("t1_bvalid_lat", bl, 0);
    do_read(32'h10, 8'd0, 3'd2, INCR, -1, rlat);
    check("t1_rvalid_lat", rlat, 0);
    check("t1_rdata", rd_data[0], 32'hDEADBEEF);
    check("t1_rresp", rd_resp[0], 2'b00);
    check("t1_rlast", rd_last[0], 1'b1);

    // INCR burst with a partial strobe on beat 2 over all-ones.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
    do_write(32'h20, 8'd3, INCR, -1, resp, wl, bl);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h0003_0003; wd[3] = 32'h4;
    ws[2] = 4'b0101;
    do_write(32'h20, 8'd3, INCR, -1, resp, wl, bl);
    check("t2_bresp", resp, 2'b00);
    do_read(32'h20, 8'd3, 3'd2, INCR, 3, rlat);
    check("t2_d0", rd_data[0], 32'h1);
    check("t2_d1", rd_data[1], 32'h2);
    check("t2_d2", rd_data[2], 32'hFF03FF03);
    check("t2_d3", rd_data[3], 32'h4);
    check("t2_last0", rd_last[0], 1'b0);
    check("t2_last2", rd_last[2], 1'b0);
    check("t2_last3", rd_last[3], 1'b1);
    check("t2_resp3", rd_resp[3], 2'b00);

    // WRAP ordering, illegal wrap length, oversize transfer.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + i; ws[i] = 4'hF; end
    do_write(32'h30, 8'd3, INCR, -1, resp, wl, bl);
    do_read(32'h38, 8'd3, 3'd2, WRAP, -1, rlat);
    check("t3_d0", rd_data[0], 32'hA000_0002);
    check("t3_d1", rd_data[1], 32'hA000_0003);
    check("t3_d2", rd_data[2], 32'hA000_0000);
    check("t3_d3", rd_data[3], 32'hA000_0001);
    check("t3_resp1", rd_resp[1], 2'b00);
    check("t3_last3", rd_last[3], 1'b1);
    do_read(32'h38, 8'd2, 3'd2, WRAP, -1, rlat);
    check("t3_len2_resp0", rd_resp[0], 2'b10);
    check("t3_len2_resp1", rd_resp[1], 2'b10);
    check("t3_len2_resp2", rd_resp[2], 2'b10);
    check("t3_len2_last2", rd_last[2], 1'b1);
    do_write(32'h80, 8'd2, WRAP, -1, resp, wl, bl);
    check("t3_len2_bresp", resp, 2'b10);
    do_read(32'h10, 8'd0, 3'd3, INCR, -1, rlat);
    check("t3_size_resp", rd_resp[0], 2'b10);

    // Out-of-range write and read across the top of the array.
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    do_write(32'h0, 8'd0, INCR, -1, resp, wl, bl);
    wd[0] = 32'h12345678;
    do_write(32'h1000, 8'd0, INCR, -1, resp, wl, bl);
    check("t4_oor_bresp", resp, 2'b10);
    do_read(32'h0, 8'd0, 3'd2, INCR, -1, rlat);
    check("t4_word0_kept", rd_data[0], 32'hCAFEF00D);
    wd[0] = 32'h5A5A5A5A;
    do_write(32'hFFC, 8'd0, INCR, -1, resp, wl, bl);
    check("t4_top_bresp", resp, 2'b00);
    do_read(32'hFFC, 8'd1, 3'd2, INCR, -1, rlat);
    check("t4_top_d0", rd_data[0], 32'h5A5A5A5A);
    check("t4_top_r0", rd_resp[0], 2'b00);
    check("t4_top_d1", rd_data[1], 32'h0);
    check("t4_top_r1", rd_resp[1], 2'b10);
    check("t4_top_last1", rd_last[1], 1'b1);

    // Early wlast on beat 1: all four beats accepted, SLVERR.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + i; ws[i] = 4'hF; end
    do_write(32'h50, 8'd3, INCR, 1, resp, wl, bl);
    check("t5_early_wlast_bresp", resp, 2'b10);

    // Asynchronous reset during beat 2 of a write burst.
    awaddr = 32'h60; awlen = 8'd3; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
    #1; check("t6_aw_ready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'h11; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    #1; check("t6_wready", wready, 1);
    @(negedge clk); wdata = 32'h22;
    @(negedge clk); wdata = 32'h33;
    #1; rst = 1'b1; #1;
    check("t6_rst_wready", wready, 0);
    check("t6_rst_bvalid", bvalid, 0);
    check("t6_rst_awready", awready, 0);
    @(negedge clk); wvalid = 1'b0; rst = 1'b0;

    // Both requests valid after reset: read, then write, then read.
    awaddr = 32'h70; awlen = 8'd0; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
    araddr = 32'h60; arlen = 8'd1; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    #1;
    check("t7_first_arready", arready, 1);
    check("t7_first_awready", awready, 0);
    @(negedge clk); arvalid = 1'b0; rready = 1'b1; #1;
    check("t7_rvalid", rvalid, 1);
    check("t7_busy_awready", awready, 0);
    check("t7_partial_d0", rdata, 32'h11);
    check("t7_partial_last0", rlast, 0);
    @(negedge clk); #1;
    check("t7_partial_d1", rdata, 32'h22);
    check("t7_partial_last1", rlast, 1);
    @(negedge clk); rready = 1'b0;
    araddr = 32'h70; arlen = 8'd0; arvalid = 1'b1; #1;
    check("t7_second_awready", awready, 1);
    check("t7_second_arready", arready, 0);
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; #1;
    check("t7_wready", wready, 1);
    @(negedge clk); wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; #1;
    check("t7_bvalid", bvalid, 1);
    check("t7_bresp", bresp, 2'b00);
    @(negedge clk); bready = 1'b0; #1;
    check("t7_third_arready", arready, 1);
    @(negedge clk); arvalid = 1'b0; #1;
    check("t7_raw_rvalid", rvalid, 1);
    check("t7_raw_rdata", rdata, 32'h77);
    check("t7_raw_rlast", rlast, 1);
    rready = 1'b1;
    @(negedge clk); rready = 1'b0; #1;
    check("t7_done_rvalid", rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
